// File: rtl/seq_mul_op.sv
// Unsigned shift-add multiplier: start sampled at edge k gives P/done in the cycle after edge k+B_W.
// start is ignored while busy; a start during the done cycle chains the next operation with no idle gap.
module seq_mul_op #(
  parameter int A_W = 4,
  parameter int B_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] A,
  input  logic [B_W-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [A_W+B_W-1:0] P,
  output logic [A_W-1:0] Y,
  output logic           C_out
);

  localparam int PW = A_W + B_W;
  localparam int CW = (B_W > 1) ? $clog2(B_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [A_W-1:0]  mcand;
  logic [B_W-1:0]  mplier;
  logic [CW-1:0]   count;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_nxt;
  logic            accept;
  logic            last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (count == CW'(B_W - 1));

  // Partial product for the multiplier bit currently at mplier[0].
  assign acc_nxt = mplier[0] ? acc + ({{B_W{1'b0}}, mcand} << count) : acc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      acc    <= '0;
      P      <= '0;
    end else if (accept) begin
      mcand  <= A;
      mplier <= B;
      count  <= '0;
      acc    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (last) P <= acc_nxt;
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign Y     = P[A_W-1:0];
  assign C_out = |P[PW-1:A_W];

endmodule

// File: tb/tb_seq_mul_op.sv
// Directed bench for seq_mul_op: default 4x2 instance plus an 8x8 instance.
module tb_seq_mul_op;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [1:0] b;
  logic       busy, done, c_out;
  logic [5:0] p;
  logic [3:0] y;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, c_out8;
  logic [15:0] p8;
  logic [7:0]  y8;

  int tests;
  int fails;

  seq_mul_op #(.A_W(4), .B_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .P(p), .Y(y), .C_out(c_out)
  );

  seq_mul_op #(.A_W(8), .B_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8), .Y(y8), .C_out(c_out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 6'd0 || y !== 4'd0 || c_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: busy=%b done=%b P=%0d Y=%b C=%b, want 0 0 0 0000 0", busy, done, p, y, c_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || p !== 6'd0 || c_out !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'd0) begin
        fails++;
        $display("FAIL idle_after_reset cycle %0d: busy=%b done=%b P=%0d C=%b P8=%0d, want all 0", i, busy, done, p, c_out, p8);
      end
    end
  endtask

  task automatic run_op(input logic [3:0] ta, input logic [1:0] tb_, input logic [5:0] ep,
                        input logic [3:0] ey, input logic ec);
    a = ta; b = tb_; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb_;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL op_%0dx%0d run1: busy=%b done=%b, want 1 0", ta, tb_, busy, done);
    end
    tick();
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL op_%0dx%0d run2: busy=%b done=%b, want 1 0", ta, tb_, busy, done);
    end
    tick();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || p !== ep || y !== ey || c_out !== ec) begin
      fails++;
      $display("FAIL op_%0dx%0d done: done=%b busy=%b P=%0d Y=%b C=%b, want 1 0 %0d %b %b",
               ta, tb_, done, busy, p, y, c_out, ep, ey, ec);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== ep) begin
      fails++;
      $display("FAIL op_%0dx%0d hold: done=%b busy=%b P=%0d, want 0 0 %0d", ta, tb_, done, busy, p, ep);
    end
  endtask

  task automatic test_default_ops();
    run_op(4'd0,  2'd0, 6'd0,  4'b0000, 1'b0);
    run_op(4'd1,  2'd1, 6'd1,  4'b0001, 1'b0);
    run_op(4'd3,  2'd1, 6'd3,  4'b0011, 1'b0);
    run_op(4'd5,  2'd2, 6'd10, 4'b1010, 1'b0);
    run_op(4'd7,  2'd3, 6'd21, 4'b0101, 1'b1);
    run_op(4'd15, 2'd3, 6'd45, 4'b1101, 1'b1);
  endtask

  task automatic test_start_during_run();
    a = 4'd7; b = 2'd3; start = 1'b1;
    tick();
    a = 4'd1; b = 2'd1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (done !== 1'b1 || p !== 6'd21) begin
      fails++;
      $display("FAIL start_in_run: done=%b P=%0d, want 1 21", done, p);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || p !== 6'd21) begin
        fails++;
        $display("FAIL start_in_run_after %0d: done=%b busy=%b P=%0d, want 0 0 21", i, done, busy, p);
      end
    end
  endtask

  task automatic test_back_to_back();
    a = 4'd5; b = 2'd2; start = 1'b1;
    tick();
    tick();
    tick();
    tests++;
    if (done !== 1'b1 || p !== 6'd10) begin
      fails++;
      $display("FAIL b2b_first: done=%b P=%0d, want 1 10", done, p);
    end
    a = 4'd15; b = 2'd3;
    tick();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || p !== 6'd10) begin
      fails++;
      $display("FAIL b2b_no_idle: busy=%b done=%b P=%0d, want 1 0 10", busy, done, p);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_early_done: done=%b, want 0", done);
    end
    tick();
    tests++;
    if (done !== 1'b1 || p !== 6'd45 || c_out !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: done=%b P=%0d C=%b, want 1 45 1", done, p, c_out);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    a = 4'd15; b = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 6'd0 || c_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b done=%b P=%0d C=%b, want 0 0 0 0", busy, done, p, c_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || p !== 6'd0) begin
        fails++;
        $display("FAIL reset_mid_run_after %0d: done=%b busy=%b P=%0d, want 0 0 0", i, done, busy, p);
      end
    end
    run_op(4'd3, 2'd1, 6'd3, 4'b0011, 1'b0);
  endtask

  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_);
    logic [15:0] ep;
    int cyc;
    ep = ta * tb_;
    a8 = ta; b8 = tb_; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done8 === 1'b1) begin
        cyc = i;
        break;
      end
    end
    tests++;
    if (cyc != 8 || p8 !== ep || y8 !== ep[7:0] || c_out8 !== (ep[15:8] != 8'd0)) begin
      fails++;
      $display("FAIL op8_%0dx%0d: cycles=%0d P=%0d Y=%h C=%b, want 8 %0d %h %b",
               ta, tb_, cyc, p8, y8, c_out8, ep, ep[7:0], ep[15:8] != 8'd0);
    end
    tick();
  endtask

  task automatic test_wide();
    run_op8(8'd255, 8'd255);
    tests++;
    if (p8 !== 16'd65025 || y8 !== 8'h01 || c_out8 !== 1'b1) begin
      fails++;
      $display("FAIL op8_255x255_const: P=%0d Y=%h C=%b, want 65025 01 1", p8, y8, c_out8);
    end
    run_op8(8'd16, 8'd15);
    tests++;
    if (p8 !== 16'd240 || c_out8 !== 1'b0) begin
      fails++;
      $display("FAIL op8_16x15_const: P=%0d C=%b, want 240 0", p8, c_out8);
    end
    run_op8(8'd0, 8'd255);
    run_op8(8'd255, 8'd0);
    for (int i = 0; i < 12; i++) begin
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_default_ops();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mul_op.md
Name: seq_mul_op

Overview:
- Parametrised sequential shift-add multiplier. It is the next-generation multiply unit for the ALU.
- Computes the unsigned product of A (A_W bits) and B (B_W bits) over B_W clock cycles.
- Uses a start/busy/done handshake.
- Presents a truncated A_W-bit result, plus a carry/overflow flag and the full-width product, to the ALU result mux.

Parameters:
- A_W, 4, width of multiplicand A and of truncated result Y (≥2)
- B_W, 2, width of multiplier B and number of iteration cycles (≥1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk, accepted only in IDLE or DONE
- A  input  A_W  unsigned multiplicand, captured on accepted start
- B  input  B_W  unsigned multiplier, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high while in DONE
- P  output  A_W+B_W  full unsigned product
- Y  output  A_W  P[A_W-1:0]
- C_out  output  1  OR-reduction of P[A_W+B_W-1:A_W]; high when the product does not fit in A_W bits

Behaviour:
- Reset: async on rst high. State=IDLE; busy=0; done=0; P=0 (so Y=0, C_out=0); internal multiplicand, multiplier and counter registers=0. Reset is released synchronously to clk edges.
- Reset mid-RUN aborts immediately. The partial product is discarded (P=0) and no done pulse is issued.
- State IDLE: on a start=1 edge, latch A into mcand and B into mplier, clear the accumulator and count, and go to RUN. Otherwise stay in IDLE.
- State RUN: on each edge, if mplier[0]=1 then acc = acc + (mcand << count). Then shift mplier right by 1 and increment count. Accumulator width is A_W+B_W; no overflow is possible.
  - After the edge that processes bit B_W-1 (count = B_W-1), load P from the final acc and go to DONE.
  - start is ignored throughout RUN. Operands and the in-flight result are unaffected.
- State DONE: done=1 for exactly one cycle.
  - If start=1 on this edge, accept the new operands and go to RUN (back-to-back throughput: one result per B_W+1 cycles).
  - Otherwise go to IDLE.
- Latency: start sampled at edge k gives P valid and done=1 in the cycle following edge k+B_W.
- Output holding: P, Y and C_out change only at the edge entering DONE (or on reset). They hold their value through IDLE and through the next RUN until the next DONE. busy=1 exactly during RUN (B_W cycles per operation).
- Arithmetic: unsigned only. The result is exact for all operand values, including all-zeros and all-ones. B=0 still takes B_W cycles and yields P=0.
- Operand changes after capture have no effect on the current operation.
- Fully synchronous datapath. No combinational path from start, A or B to any output.

Test Plan:
- Reset then idle: assert rst asynchronously between edges → busy=0, done=0, P=0, Y=0, C_out=0 immediately. With start=0 for 5 cycles, all outputs stay 0.
- Default params (4x2), sequence (0,0), (1,1), (3,1), (5,2), (7,3), (15,3), each issued only after the previous done:
  - (0,0) → P=0, Y=0000, C_out=0
  - (1,1) → P=1, Y=0001, C_out=0
  - (3,1) → P=3, Y=0011, C_out=0
  - (5,2) → P=10, Y=1010, C_out=0
  - (7,3) → P=21, Y=0101, C_out=1
  - (15,3) → P=45, Y=1101, C_out=1
  - For each operation, done is high exactly 2 cycles after the start edge, and busy is high for 2 cycles.
- Start during RUN: issue A=7, B=3, then next cycle start with A=1, B=1 → the second request is ignored. Result is P=21; no second done follows.
- Back-to-back: hold start=1 with A=5, B=2, then drive A=15, B=3 during the done cycle → P=10 at the first done, P=45 at the second done. The done pulses are 3 cycles apart, and there is no IDLE cycle between them.
- Reset mid-operation: start A=15, B=3, then assert rst one cycle later → P=0, busy=0, no done pulse. After release, A=3, B=1 yields P=3 normally.
- Parameter sweep A_W=8, B_W=8: 255*255 → P=65025, Y=0x01, C_out=1, done 8 cycles after start. 16*15 → P=240, C_out=0. Also run randomised operands against a reference product.
